// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional build macro used by the top: FIFO_WR_ARB_STATS_EN.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Per-requester grant statistics counters
   localparam int unsigned       STAT_W   = 32'd16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   // (base + off) modulo n, for base < n and off < n
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned sum;
      sum = base + off;
      if (sum >= n) begin
         sum = sum - n;
      end else begin
         sum = sum;
      end
      return sum;
   endfunction

   // (idx + 1) modulo n, for idx < n
   function automatic int unsigned wrap_inc(input int unsigned idx,
                                            input int unsigned n);
      return wrap_add(idx, 32'd1, n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping past the top index back to zero.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N     = 32'd4,
   parameter int unsigned IDX_W = 32'd2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] cand_s;

   // Scan N candidates starting at ptr and keep the first one that is requesting
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand_s  = '0;
      for (int unsigned k = 32'd0; k < N; k++) begin
         cand_s = IDX_W'(wrap_add(int'(ptr_i), k, N));
         if (!found_o && req_i[cand_s]) begin
            found_o = 1'b1;
            idx_o   = cand_s;
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one FIFO write port among NUM_REQ
// producers. A grant is held until the owner's last word or BURST_MAX beats.
// Define FIFO_WR_ARB_STATS_EN to add per-requester 16-bit grant counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 32'd4,
   parameter int unsigned DATA_WIDTH = 32'd32,
   parameter int unsigned BURST_MAX  = 32'd4,
   localparam int unsigned IDX_W     = $clog2(NUM_REQ),
   localparam int unsigned CNT_W     = $clog2(BURST_MAX + 32'd1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_grants
`endif
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic             pick_found_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             owner_valid_s;
   logic             owner_last_s;
   logic             burst_end_s;

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found_s),
      .idx_o   (pick_idx_s)
   );

   assign owner_valid_s = req_valid[grant_q];
   assign owner_last_s  = req_last[grant_q];
   assign burst_end_s   = ((int'(beat_cnt_q) + 32'd1) == BURST_MAX);

   assign grant_id = grant_q;
   assign busy     = (state_q == ARB_LOCKED);

   // Owner-side handshake and write strobe; zero-cycle path from inputs while locked
   always_comb begin
      req_ready = '0;
      fifo_wr   = 1'b0;
      fifo_din  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      if (state_q == ARB_LOCKED) begin
         req_ready[grant_q] = !fifo_full;
         fifo_wr            = owner_valid_s && !fifo_full;
      end else begin
         fifo_wr = 1'b0;
      end
   end

   // Next-state: pick in IDLE, count beats and release in LOCKED
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found_s) begin
               state_d    = ARB_LOCKED;
               grant_d    = pick_idx_s;
               beat_cnt_d = '0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_LOCKED: begin
            if (fifo_wr) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (owner_last_s || burst_end_s) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));
               end else begin
                  state_d = ARB_LOCKED;
               end
            end else begin
               state_d = ARB_LOCKED;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];

   // Saturating count of IDLE->LOCKED grants per requester
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 32'd0; i < NUM_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else if ((state_q == ARB_IDLE) && pick_found_s) begin
         if (stat_q[pick_idx_s] != STAT_MAX) begin
            stat_q[pick_idx_s] <= stat_q[pick_idx_s] + 16'd1;
         end else begin
            stat_q[pick_idx_s] <= STAT_MAX;
         end
      end else begin
         stat_q <= stat_q;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      assign stat_grants[gi*STAT_W +: STAT_W] = stat_q[gi];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, BURST_MAX=4).
// Stimulus pushes hand-computed {owner, word} pairs; a negedge monitor pops and
// compares on every FIFO write. The FIFO itself is modelled by the expected queue.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              fifo_full;
   logic              fifo_wr;
   logic [DW-1:0]     fifo_din;
   logic [1:0]        grant_id;
   logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NR*16-1:0]  stat_grants;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_MAX  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr    (fifo_wr),
      .fifo_din   (fifo_din),
      .grant_id   (grant_id),
      .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [1:0] id; logic [31:0] d; } exp_t;
   typedef struct packed { logic [31:0] d; logic last; } word_t;

   exp_t  exp_q [$];
   word_t pq [NR][$];
   int    chk_cnt  = 0;
   int    pass_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_push(input logic [1:0] id, input logic [31:0] d);
      exp_t e;
      e.id = id;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   task automatic pkt(input int r, input logic [31:0] d, input logic last);
      word_t w;
      w.d    = d;
      w.last = last;
      pq[r].push_back(w);
   endtask

   function automatic bit pq_empty();
      for (int i = 0; i < NR; i++) if (pq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (pq[i].size() != 0) begin
            req_valid[i]         = 1'b1;
            req_data[i*DW +: DW] = pq[i][0].d;
            req_last[i]          = pq[i][0].last;
         end else begin
            req_valid[i]         = 1'b0;
            req_data[i*DW +: DW] = '0;
            req_last[i]          = 1'b0;
         end
      end
   endtask

   // One cycle: sample handshakes mid-cycle, retire accepted words after the edge
   task automatic tick();
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) void'(pq[i].pop_front());
      drive();
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !pq_empty()) && n < 200) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      tick();
      tick();
   endtask

   // Monitor: every FIFO write must match the next expected word and owner
   always @(negedge clk) begin
      if (rst_n) begin
         if (fifo_full) chk("no_wr_rdy_when_full", {59'd0, fifo_wr, req_ready}, 64'd0);
         if (fifo_wr) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_write: got data %0h expected no write", fifo_din);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("wr_data", 64'(fifo_din), 64'(e.d));
               chk("wr_owner", 64'(grant_id), 64'(e.id));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      fifo_full = 1'b0;
      req_valid = 4'hF;
      req_data  = '0;
      req_last  = 4'hF;
      #3;
      chk("rst_outputs", {56'd0, req_ready, fifo_wr, busy, grant_id}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_outputs", {56'd0, req_ready, fifo_wr, busy, grant_id}, 64'd0);
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: req1 alone, 3-word packet; no write in the pick cycle
      pkt(1, 32'h5A, 1'b0); pkt(1, 32'hF6, 1'b0); pkt(1, 32'h09, 1'b1);
      exp_push(2'd1, 32'h5A); exp_push(2'd1, 32'hF6); exp_push(2'd1, 32'h09);
      drive();
      @(negedge clk);
      chk("pick_cycle_no_write", {62'd0, fifo_wr, busy}, 64'd0);
      wait_done("s1_done");
      chk("s1_idle", 64'(busy), 64'd0);

      // req3 single word moves rr_ptr from 2 back to 0
      pkt(3, 32'h33, 1'b1);
      exp_push(2'd3, 32'h33);
      drive();
      wait_done("s1b_done");

      // 2: all four valid, req0 has a second packet -> grants 0,1,2,3,0
      pkt(0, 32'hA0, 1'b1); pkt(0, 32'hA4, 1'b1);
      pkt(1, 32'hB1, 1'b1); pkt(2, 32'hC2, 1'b1); pkt(3, 32'hD3, 1'b1);
      exp_push(2'd0, 32'hA0); exp_push(2'd1, 32'hB1); exp_push(2'd2, 32'hC2);
      exp_push(2'd3, 32'hD3); exp_push(2'd0, 32'hA4);
      drive();
      wait_done("s2_done");
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stat_req0", 64'(stat_grants[0*16 +: 16]), 64'd2);
      chk("stat_req1", 64'(stat_grants[1*16 +: 16]), 64'd2);
      chk("stat_req2", 64'(stat_grants[2*16 +: 16]), 64'd1);
      chk("stat_req3", 64'(stat_grants[3*16 +: 16]), 64'd2);
`endif

      // 3: rr_ptr=1; req2 6-word packet forced out after 4 beats, req3 interleaves
      for (int k = 0; k < 6; k++) pkt(2, 32'h20 + 32'(k), (k == 5));
      pkt(3, 32'h30, 1'b1);
      exp_push(2'd2, 32'h20); exp_push(2'd2, 32'h21); exp_push(2'd2, 32'h22);
      exp_push(2'd2, 32'h23); exp_push(2'd3, 32'h30);
      exp_push(2'd2, 32'h24); exp_push(2'd2, 32'h25);
      drive();
      wait_done("s3_done");

      // 4: rr_ptr=3; req1 4-word packet with FIFO full for 5 cycles mid-packet
      for (int k = 0; k < 4; k++) pkt(1, 32'h40 + 32'(k), (k == 3));
      for (int k = 0; k < 4; k++) exp_push(2'd1, 32'h40 + 32'(k));
      drive();
      for (int c = 0; c < 12; c++) begin
         fifo_full = (c >= 3 && c < 8);
         tick();
      end
      fifo_full = 1'b0;
      wait_done("s4_done");

      // 5: rr_ptr=2; req2 packet cut by reset after two beats
      for (int k = 0; k < 4; k++) pkt(2, 32'h50 + 32'(k), (k == 3));
      exp_push(2'd2, 32'h50); exp_push(2'd2, 32'h51);
      drive();
      begin
         int n;
         n = 0;
         while (pq[2].size() > 2 && n < 50) begin
            tick();
            n++;
         end
      end
      chk("s5_pre_reset_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("s5_reset_outputs", {56'd0, req_ready, fifo_wr, busy, grant_id}, 64'd0);
      chk("s5_beats_before_reset", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < NR; i++) pq[i].delete();
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // rr_ptr back at 0: req1 must win over req3
      pkt(1, 32'h71, 1'b1);
      pkt(3, 32'h60, 1'b0); pkt(3, 32'h61, 1'b0); pkt(3, 32'h62, 1'b1);
      exp_push(2'd1, 32'h71);
      exp_push(2'd3, 32'h60); exp_push(2'd3, 32'h61); exp_push(2'd3, 32'h62);
      drive();
      wait_done("s5_done");
      chk("final_idle", {62'd0, busy, fifo_wr}, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
